// File: rtl/evm_pkg.sv
// Shared definitions for the voting-machine result reader: state enum,
// candidate codes and the select code that blanks the machine's outputs.
package evm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_C1,
    ST_READ_C2,
    ST_READ_C3,
    ST_READ_WIN,
    ST_REPORT,
    ST_HOLD
  } rd_state_e;

  localparam logic [1:0] CAND_1    = 2'b01;
  localparam logic [1:0] CAND_2    = 2'b10;
  localparam logic [1:0] CAND_3    = 2'b11;
  localparam logic [1:0] DISP_NONE = 2'b11;

  // Candidate select driven while a given state is current.
  function automatic logic [1:0] disp_sel(input rd_state_e st);
    case (st)
      ST_READ_C1: return 2'b00;
      ST_READ_C2: return 2'b01;
      ST_READ_C3: return 2'b10;
      default:    return DISP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/evm_result_reader.sv
// Reads back per-candidate counts and the winner after voting_done, checks
// consistency and offers one registered report. Option: EVM_READER_TOTAL_EN.
module evm_result_reader
  import evm_pkg::*;
#(
  parameter int unsigned WIDTH         = 7,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             voting_done,
  input  logic             invalid_results,
  input  logic [1:0]       candidate_name,
  input  logic [WIDTH-1:0] results,
  output logic [1:0]       display_results,
  output logic             display_winner,
  input  logic             report_ready,
  output logic             report_valid,
  output logic [WIDTH-1:0] count_1,
  output logic [WIDTH-1:0] count_2,
  output logic [WIDTH-1:0] count_3,
  output logic [1:0]       winner_name,
  output logic [WIDTH-1:0] winner_count,
  output logic             tie,
  output logic             proto_err,
  output logic             read_abort
`ifdef EVM_READER_TOTAL_EN
  ,
  output logic [WIDTH+1:0] total_votes
`endif
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  rd_state_e        state_q, state_d;
  logic             vd_q;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       disp_q, disp_d;
  logic             win_q, win_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [1:0]       wn_q, wn_d;
  logic [WIDTH-1:0] wc_q, wc_d;
  logic             tie_q, tie_d, perr_q, perr_d, abort_q, abort_d;
  logic             last_cycle, reading;

  assign last_cycle = (cnt_q == SETTLE_LAST);
  assign reading    = (state_q == ST_READ_C1) || (state_q == ST_READ_C2) ||
                      (state_q == ST_READ_C3) || (state_q == ST_READ_WIN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    c3_d    = c3_q;
    wn_d    = wn_q;
    wc_d    = wc_q;
    tie_d   = tie_q;
    perr_d  = perr_q;
    abort_d = 1'b0;

    if (reading && !voting_done) begin
      // Abort takes priority over a sample due in the same cycle.
      state_d = ST_IDLE;
      cnt_d   = '0;
      abort_d = 1'b1;
      tie_d   = 1'b0;
      perr_d  = 1'b0;
    end else if (reading && !last_cycle) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (voting_done && !vd_q) begin
            state_d = ST_READ_C1;
            tie_d   = 1'b0;
            perr_d  = 1'b0;
          end
        end
        ST_READ_C1: begin
          if (candidate_name != CAND_1) perr_d = 1'b1;
          if (invalid_results) begin
            tie_d   = 1'b1;
            c1_d    = '0;
            c2_d    = '0;
            c3_d    = '0;
            wn_d    = '0;
            wc_d    = '0;
            state_d = ST_REPORT;
          end else begin
            c1_d    = results;
            state_d = ST_READ_C2;
          end
        end
        ST_READ_C2: begin
          if (candidate_name != CAND_2) perr_d = 1'b1;
          c2_d    = results;
          state_d = ST_READ_C3;
        end
        ST_READ_C3: begin
          if (candidate_name != CAND_3) perr_d = 1'b1;
          c3_d    = results;
          state_d = ST_READ_WIN;
        end
        ST_READ_WIN: begin
          wn_d = candidate_name;
          wc_d = results;
          case (candidate_name)
            CAND_1:  if (results != c1_q) perr_d = 1'b1;
            CAND_2:  if (results != c2_q) perr_d = 1'b1;
            CAND_3:  if (results != c3_q) perr_d = 1'b1;
            default: perr_d = 1'b1;
          endcase
          state_d = ST_REPORT;
        end
        ST_REPORT: if (valid_q && report_ready) state_d = ST_HOLD;
        ST_HOLD:   if (!voting_done) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // Selects and valid are registered from the next state so they line up
    // with the state they belong to.
    disp_d  = disp_sel(state_d);
    win_d   = (state_d == ST_READ_WIN);
    valid_d = (state_d == ST_REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vd_q    <= 1'b0;
      cnt_q   <= '0;
      disp_q  <= DISP_NONE;
      win_q   <= 1'b0;
      valid_q <= 1'b0;
      c1_q    <= '0;
      c2_q    <= '0;
      c3_q    <= '0;
      wn_q    <= '0;
      wc_q    <= '0;
      tie_q   <= 1'b0;
      perr_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vd_q    <= voting_done;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
      wn_q    <= wn_d;
      wc_q    <= wc_d;
      tie_q   <= tie_d;
      perr_q  <= perr_d;
      abort_q <= abort_d;
    end
  end

`ifdef EVM_READER_TOTAL_EN
  logic [WIDTH+1:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (state_d == ST_REPORT && state_q != ST_REPORT)
      total_d = {2'b00, c1_d} + {2'b00, c2_d} + {2'b00, c3_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign total_votes = total_q;
`endif

  assign display_results = disp_q;
  assign display_winner  = win_q;
  assign report_valid    = valid_q;
  assign count_1         = c1_q;
  assign count_2         = c2_q;
  assign count_3         = c3_q;
  assign winner_name     = wn_q;
  assign winner_count    = wc_q;
  assign tie             = tie_q;
  assign proto_err       = perr_q;
  assign read_abort      = abort_q;

endmodule

// File: tb/tb_evm_result_reader.sv
// Bench for evm_result_reader: emulates the voting machine's combinational
// result bus and checks the reader against a session-level timeline model.
module tb_evm_result_reader;

  localparam int W = 7;
  localparam int S = 1;

  logic         clk, rst, voting_done, invalid_results, report_ready;
  logic [1:0]   candidate_name, display_results, winner_name;
  logic [W-1:0] results, count_1, count_2, count_3, winner_count;
  logic         display_winner, report_valid, tie, proto_err, read_abort;
`ifdef EVM_READER_TOTAL_EN
  logic [W+1:0] total_votes;
`endif

  // Current session as seen by the emulated voting machine
  logic [W-1:0] c1 = '0, c2 = '0, c3 = '0, w_cnt = '0;
  logic [1:0]   w_code = 2'b00;
  bit           s_inv = 1'b0;
  int           s_fault = 0;

  int n_checks = 0, n_fail = 0;

  // Model state and expectations for the current cycle
  int         m_mode = 0, m_k = 0;
  bit         m_prev = 1'b0;
  logic [1:0] e_disp = 2'b11;
  bit         e_win = 1'b0, e_valid = 1'b0, e_abort = 1'b0, e_tie = 1'b0, e_perr = 1'b0;
  int         e_c1 = 0, e_c2 = 0, e_c3 = 0, e_wn = 0, e_wc = 0, e_total = 0;

  // Per-session observations
  int lat, vcnt, acnt;
  int sn_c1, sn_c2, sn_c3, sn_wn, sn_wc, sn_tie, sn_perr, sn_total;

  evm_result_reader #(
    .WIDTH        (W),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .voting_done    (voting_done),
    .invalid_results(invalid_results),
    .candidate_name (candidate_name),
    .results        (results),
    .display_results(display_results),
    .display_winner (display_winner),
    .report_ready   (report_ready),
    .report_valid   (report_valid),
    .count_1        (count_1),
    .count_2        (count_2),
    .count_3        (count_3),
    .winner_name    (winner_name),
    .winner_count   (winner_count),
    .tie            (tie),
    .proto_err      (proto_err),
    .read_abort     (read_abort)
`ifdef EVM_READER_TOTAL_EN
    ,
    .total_votes    (total_votes)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Voting machine result bus; s_fault 1 corrupts the C3 name, 2 the winner count
  always_comb begin
    candidate_name = 2'b00;
    results        = '0;
    if (display_winner) begin
      candidate_name = w_code;
      results        = (s_fault == 2) ? w_cnt + 1'b1 : w_cnt;
    end else begin
      case (display_results)
        2'b00: begin candidate_name = 2'b01; results = c1; end
        2'b01: begin candidate_name = 2'b10; results = c2; end
        2'b10: begin candidate_name = (s_fault == 1) ? 2'b00 : 2'b11; results = c3; end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_prev = 1'b0;
    e_disp = 2'b11; e_win = 1'b0; e_valid = 1'b0; e_abort = 1'b0;
    e_tie = 1'b0; e_perr = 1'b0;
    e_c1 = 0; e_c2 = 0; e_c3 = 0; e_wn = 0; e_wc = 0; e_total = 0;
  endtask

  // Session timeline: reading lasts S cycles per select (S only on a tie),
  // then the report stays up until accepted, then hold until done drops.
  task automatic model_step();
    int len;
    len = s_inv ? S : 4 * S;
    e_abort = 1'b0;
    case (m_mode)
      0: if (voting_done && !m_prev) begin
           m_mode = 1; m_k = 1; e_tie = 1'b0; e_perr = 1'b0;
         end
      1: if (!voting_done) begin
           m_mode = 0; e_abort = 1'b1; e_tie = 1'b0; e_perr = 1'b0;
         end else if (m_k < len) begin
           m_k++;
         end else begin
           m_mode = 2;
           if (s_inv) begin
             e_c1 = 0; e_c2 = 0; e_c3 = 0; e_wn = 0; e_wc = 0; e_total = 0;
             e_tie = 1'b1; e_perr = 1'b0;
           end else begin
             e_c1 = int'(c1); e_c2 = int'(c2); e_c3 = int'(c3);
             e_wn = int'(w_code);
             e_wc = (s_fault == 2) ? (int'(w_cnt) + 1) % (1 << W) : int'(w_cnt);
             e_total = int'(c1) + int'(c2) + int'(c3);
             e_tie = 1'b0; e_perr = (s_fault != 0);
           end
         end
      2: if (report_ready) m_mode = 3;
      default: if (!voting_done) m_mode = 0;
    endcase
    m_prev  = voting_done;
    e_valid = (m_mode == 2);
    e_win   = (m_mode == 1) && ((m_k - 1) / S == 3);
    e_disp  = (m_mode == 1 && (m_k - 1) / S < 3) ? 2'((m_k - 1) / S) : 2'b11;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      check("report_valid", int'(report_valid), int'(e_valid));
      check("read_abort", int'(read_abort), int'(e_abort));
      check("display_results", int'(display_results), int'(e_disp));
      check("display_winner", int'(display_winner), int'(e_win));
      if (e_valid) begin
        check("count_1", int'(count_1), e_c1);
        check("count_2", int'(count_2), e_c2);
        check("count_3", int'(count_3), e_c3);
        check("winner_name", int'(winner_name), e_wn);
        check("winner_count", int'(winner_count), e_wc);
        check("tie", int'(tie), int'(e_tie));
        check("proto_err", int'(proto_err), int'(e_perr));
`ifdef EVM_READER_TOTAL_EN
        check("total_votes", int'(total_votes), e_total);
`endif
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_display_results"}, int'(display_results), 3);
    check({tag, "_display_winner"}, int'(display_winner), 0);
    check({tag, "_report_valid"}, int'(report_valid), 0);
    check({tag, "_read_abort"}, int'(read_abort), 0);
    check({tag, "_count_1"}, int'(count_1), 0);
    check({tag, "_winner_count"}, int'(winner_count), 0);
    check({tag, "_tie"}, int'(tie), 0);
    check({tag, "_proto_err"}, int'(proto_err), 0);
`ifdef EVM_READER_TOTAL_EN
    check({tag, "_total_votes"}, int'(total_votes), 0);
`endif
  endtask

  // rmode: 0 ready always high, 1 ready low for the first 10 report cycles,
  // 2 random ready. abort_k / rst_k: cycle after E to drop done / pulse rst.
  task automatic run_session(input int a1, input int a2, input int a3, input bit inv,
                             input int flt, input int rmode, input int abort_k,
                             input int rst_k);
    bit done;
    @(negedge clk);
    c1 = W'(a1); c2 = W'(a2); c3 = W'(a3);
    if (a1 >= a2 && a1 >= a3) begin w_code = 2'b01; w_cnt = W'(a1); end
    else if (a2 >= a3)        begin w_code = 2'b10; w_cnt = W'(a2); end
    else                      begin w_code = 2'b11; w_cnt = W'(a3); end
    s_inv = inv; s_fault = flt; invalid_results = inv;
    report_ready = (rmode == 0);
    lat = -1; vcnt = 0; acnt = 0; done = 1'b0;
    voting_done = 1'b1;
    for (int t = 1; t <= 200 && !done; t++) begin
      @(negedge clk);
      if (report_valid) begin
        if (lat < 0) begin
          lat = t;
          sn_c1 = int'(count_1); sn_c2 = int'(count_2); sn_c3 = int'(count_3);
          sn_wn = int'(winner_name); sn_wc = int'(winner_count);
          sn_tie = int'(tie); sn_perr = int'(proto_err);
`ifdef EVM_READER_TOTAL_EN
          sn_total = int'(total_votes);
`else
          sn_total = 0;
`endif
        end
        vcnt++;
      end
      if (read_abort) acnt++;
      if (rst_k == t) begin
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        voting_done = 1'b0; invalid_results = 1'b0; report_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (abort_k == t) voting_done = 1'b0;
      if (abort_k != 0 && t == abort_k + 2) done = 1'b1;
      if (rmode == 1)      report_ready = (vcnt >= 11);
      else if (rmode == 2) report_ready = ($urandom_range(0, 3) != 0);
      if (report_valid && report_ready) done = 1'b1;
    end
    check("session_completed", int'(done), 1);
    if (abort_k == 0) repeat (3) @(negedge clk);
    voting_done = 1'b0; report_ready = 1'b0; invalid_results = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2, a3, mx, nmx, flt, ab, r;
    bit inv;
    rst = 1'b1; voting_done = 1'b0; invalid_results = 1'b0; report_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_session(5, 3, 2, 1'b0, 0, 0, 0, 0);
    check("t532_latency", lat, 5);
    check("t532_valid_cycles", vcnt, 1);
    check("t532_count_1", sn_c1, 5);
    check("t532_count_2", sn_c2, 3);
    check("t532_count_3", sn_c3, 2);
    check("t532_winner_name", sn_wn, 1);
    check("t532_winner_count", sn_wc, 5);
    check("t532_tie", sn_tie, 0);
    check("t532_proto_err", sn_perr, 0);
`ifdef EVM_READER_TOTAL_EN
    check("t532_total_votes", sn_total, 10);
`endif

    run_session(4, 4, 1, 1'b1, 0, 0, 0, 0);
    check("tie_latency", lat, 2);
    check("tie_flag", sn_tie, 1);
    check("tie_count_1", sn_c1, 0);
    check("tie_count_2", sn_c2, 0);
    check("tie_winner_name", sn_wn, 0);

    run_session(3, 7, 2, 1'b0, 0, 0, 2, 0);
    check("abort_pulses", acnt, 1);
    check("abort_valid_cycles", vcnt, 0);
    check("abort_display_results", int'(display_results), 3);

    run_session(1, 6, 0, 1'b0, 0, 1, 0, 0);
    check("stall_valid_cycles", vcnt, 11);
    check("stall_count_2", sn_c2, 6);
    check("stall_winner_name", sn_wn, 2);

    run_session(2, 1, 3, 1'b0, 1, 0, 0, 0);
    check("c3fault_proto_err", sn_perr, 1);
    check("c3fault_count_3", sn_c3, 3);

    run_session(5, 3, 2, 1'b0, 0, 0, 0, 4);
    repeat (2) @(negedge clk);
    run_session(5, 3, 2, 1'b0, 0, 0, 0, 0);
    check("after_rst_latency", lat, 5);
    check("after_rst_count_1", sn_c1, 5);
    check("after_rst_winner_count", sn_wc, 5);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        a1 = $urandom_range(0, (1 << W) - 1);
        a2 = $urandom_range(0, (1 << W) - 1);
        a3 = $urandom_range(0, (1 << W) - 1);
      end else begin
        a1 = $urandom_range(0, 4);
        a2 = $urandom_range(0, 4);
        a3 = $urandom_range(0, 4);
      end
      mx  = (a1 > a2) ? a1 : a2;
      mx  = (a3 > mx) ? a3 : mx;
      nmx = int'(a1 == mx) + int'(a2 == mx) + int'(a3 == mx);
      inv = (nmx > 1);
      r   = $urandom_range(0, 9);
      flt = (r == 8) ? 1 : (r == 9) ? 2 : 0;
      ab  = ($urandom_range(0, 6) == 0) ? $urandom_range(1, inv ? S : 4 * S) : 0;
      run_session(a1, a2, a3, inv, flt, 2, ab, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
